fc_out_serializer: RTL

FC_OUT_SERIALIZER -- requirements
Module: fc_out_serializer

---
 rtl/fc_out_serializer_if.sv | 26 ++
 rtl/fc_out_serializer.sv | 88 ++++++++
 2 files changed

// File: rtl/fc_out_serializer_if.sv
// Handshake bundle for the FC output serializer: vector capture side,
// element stream side and the sticky drop flag.
interface fc_out_serializer_if #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32
);
  logic                        in_valid;
  logic signed [ACC_WIDTH-1:0] fc_in [NUM_NEURONS];
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                        out_last;
  logic                        overflow;

  modport master (
    output in_valid, fc_in, out_ready,
    input  in_ready, out_valid, out_data, out_last, overflow
  );

  modport slave (
    input  in_valid, fc_in, out_ready,
    output in_ready, out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/fc_out_serializer.sv
// Captures a vector of layer accumulators and streams it out one requantized
// element per transfer (shift, optional ReLU, saturate).
//
// state | meaning
// IDLE  | no vector buffered, ready to capture
// SEND  | streaming buffered element idx to the output
module fc_out_serializer #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int FRAC_BITS   = 8,
  parameter int RELU_EN     = 1
) (
  input logic clk,
  input logic rst_n,
  fc_out_serializer_if.slave bus
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [0:0]                  state;
  logic [IDX_W-1:0]            idx;
  logic                        overflow_q;
  logic signed [ACC_WIDTH-1:0] cap_buf [NUM_NEURONS];

  logic sending;
  logic at_last;
  logic xfer;
  logic capture;
  logic drop;

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] relu_val;
  logic signed [ACC_WIDTH-1:0] sat_val;

  assign sending = (state == ST_SEND);
  assign at_last = (idx == LAST_IDX);
  assign xfer    = sending & bus.out_ready;

  // Ready during the final transfer lets a new vector follow with no bubble.
  assign bus.in_ready = ~sending | (bus.out_ready & at_last);
  assign capture      = bus.in_valid & bus.in_ready;
  assign drop         = bus.in_valid & ~bus.in_ready;

  always_comb begin
    shifted  = cap_buf[idx] >>> FRAC_BITS;
    relu_val = shifted;
    if ((RELU_EN != 0) && (shifted < 0)) relu_val = '0;
    sat_val = relu_val;
    if (relu_val > SAT_MAX)      sat_val = SAT_MAX;
    else if (relu_val < SAT_MIN) sat_val = SAT_MIN;
  end

  assign bus.out_valid = sending;
  assign bus.out_data  = sending ? DATA_WIDTH'(sat_val) : '0;
  assign bus.out_last  = sending & at_last;
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (capture) begin
        state <= ST_SEND;
        idx   <= '0;
      end else if (xfer) begin
        if (at_last) state <= ST_IDLE;
        else         idx   <= idx + IDX_W'(1);
      end
    end
  end

  // Data path only; the FSM decides whether the contents are meaningful.
  always_ff @(posedge clk) begin
    if (capture) cap_buf <= bus.fc_in;
  end
endmodule
